// File: rtl/memory_stage_reg.sv
// Execute-to-memory pipeline register with load/store unit.
// Runs the data-memory access over a valid/ready port and stalls the front end while it waits.
module memory_stage_reg #(
    parameter int unsigned DPW     = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           regwriteE,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic [2:0]     funct3E,
    input  logic [DPW-1:0] aluresultE,
    input  logic [DPW-1:0] writedataE,
    input  logic [4:0]     RdE,
    output logic           regwriteM,
    output logic           resultsrcM,
    output logic [DPW-1:0] aluresultM,
    output logic [DPW-1:0] ReadDataM,
    output logic [4:0]     RdM,
    output logic           stallM,
    output logic           memerrM,
    output logic           dmem_timeout,
    output logic           dmem_valid,
    output logic           dmem_we,
    output logic [DPW-1:0] dmem_addr,
    output logic [3:0]     dmem_be,
    output logic [DPW-1:0] dmem_wdata,
    input  logic           dmem_ready,
    input  logic [DPW-1:0] dmem_rdata
);
    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StWait  = 1'b1;
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    logic           regwrite_q;
    logic           resultsrc_q;
    logic           memwrite_q;
    logic [2:0]     funct3_q;
    logic [DPW-1:0] aluresult_q;
    logic [DPW-1:0] writedata_q;
    logic [4:0]     rd_q;
    logic [7:0]     cnt_q, cnt_d;
    logic [0:0]     state_q, state_d;

    logic           memreq;
    logic           illegal_f3;
    logic           misaligned;
    logic           memerr;
    logic           memop;
    logic           timeout;
    logic           stall;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [DPW-1:0] load_ext;

    // Reset clears every field, which leaves a bubble in M.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            funct3_q    <= 3'b000;
            aluresult_q <= '0;
            writedata_q <= '0;
            rd_q        <= 5'd0;
        end else if (!stall) begin
            regwrite_q  <= regwriteE;
            resultsrc_q <= resultsrcE;
            memwrite_q  <= memwriteE;
            funct3_q    <= funct3E;
            aluresult_q <= aluresultE;
            writedata_q <= writedataE;
            rd_q        <= RdE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        memreq     = resultsrc_q | memwrite_q;
        illegal_f3 = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
        misaligned = ((funct3_q[1:0] == 2'b01) && aluresult_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (aluresult_q[1:0] != 2'b00));
        memerr     = memreq & (illegal_f3 | misaligned);
        memop      = memreq & ~memerr;
        timeout    = memop & ~dmem_ready & (cnt_q == CntLast);
        stall      = memop & ~dmem_ready & ~timeout;
    end

    // The count clears whenever the register advances, including on a timeout.
    always_comb begin
        cnt_d   = stall ? cnt_q + 8'd1 : 8'd0;
        state_d = state_q;
        case (state_q)
            StIdle:  if (stall)  state_d = StWait;
            StWait:  if (!stall) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = '0;
        if (memop) begin
            if (memwrite_q) begin
                case (funct3_q[1:0])
                    2'b00: begin
                        dmem_be    = 4'b0001 << aluresult_q[1:0];
                        dmem_wdata = {4{writedata_q[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = 4'b0011 << aluresult_q[1:0];
                        dmem_wdata = {2{writedata_q[15:0]}};
                    end
                    default: begin
                        dmem_be    = 4'b1111;
                        dmem_wdata = writedata_q;
                    end
                endcase
            end else begin
                dmem_be = 4'b1111;
            end
        end
    end

    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (aluresult_q[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = aluresult_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{(DPW-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {{(DPW-8){1'b0}}, byte_sel};
            3'b001:  load_ext = {{(DPW-16){half_sel[15]}}, half_sel};
            3'b101:  load_ext = {{(DPW-16){1'b0}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    // W samples every clock, so stalled or aborted cycles must look like bubbles.
    always_comb begin
        regwriteM    = regwrite_q & ~stall & ~memerr & ~timeout;
        resultsrcM   = resultsrc_q;
        aluresultM   = aluresult_q;
        RdM          = rd_q;
        ReadDataM    = (memop & resultsrc_q & dmem_ready) ? load_ext : '0;
        stallM       = stall;
        memerrM      = memerr;
        dmem_timeout = timeout;
        dmem_valid   = memop;
        dmem_we      = memwrite_q;
        dmem_addr    = {aluresult_q[DPW-1:2], 2'b00};
    end

endmodule
